// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// cnn_defs : shared constants for the CNN datapath blocks.
//   DFLT_DATA_WIDTH       default feature/kernel element width
//   DFLT_KERNEL_SIZE      default window edge length
//   DFLT_MAC_RESULT_WIDTH default width of the signed MAC result
//   MAC_SUM_WIDTH         exact accumulator width for the default geometry
//   mac_sum_width()       same derivation for any DATA_WIDTH / KERNEL_SIZE
// ---------------------------------------------------------------------------
package cnn_defs;

  localparam int DFLT_DATA_WIDTH       = 8;
  localparam int DFLT_KERNEL_SIZE      = 3;
  localparam int DFLT_MAC_RESULT_WIDTH = 32;

  // Each product needs 2*DW+1 bits (unsigned feature widened by one bit times
  // a signed weight); summing N^2 of them grows by clog2(N^2) bits.
  function automatic int mac_sum_width(input int dw, input int ks);
    return 2 * dw + 1 + $clog2(ks * ks);
  endfunction

  localparam int MAC_SUM_WIDTH = mac_sum_width(DFLT_DATA_WIDTH, DFLT_KERNEL_SIZE);

endpackage

// File: rtl/mac_if.sv
// ---------------------------------------------------------------------------
// mac_if : window/result bus of the MAC.
//   in_valid  feature/kernel valid this cycle
//   feature   KERNEL_SIZE x KERNEL_SIZE unsigned activations, [row][col]
//   kernel    KERNEL_SIZE x KERNEL_SIZE two's-complement weights, [row][col]
//   result    signed sum of element-wise products
//   out_valid result belongs to an accepted window
// master drives the window, slave (the MAC) drives the result.
// ---------------------------------------------------------------------------
interface mac_if #(
  parameter int DATA_WIDTH       = cnn_defs::DFLT_DATA_WIDTH,
  parameter int KERNEL_SIZE      = cnn_defs::DFLT_KERNEL_SIZE,
  parameter int MAC_RESULT_WIDTH = cnn_defs::DFLT_MAC_RESULT_WIDTH
);

  logic                                                  in_valid;
  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] feature;
  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] kernel;
  logic signed [MAC_RESULT_WIDTH-1:0]                    result;
  logic                                                  out_valid;

  modport master (
    output in_valid, feature, kernel,
    input  result, out_valid
  );

  modport slave (
    input  in_valid, feature, kernel,
    output result, out_valid
  );

endinterface

// File: rtl/mac_pe.sv
// ---------------------------------------------------------------------------
// mac_pe : one unsigned-by-signed multiply.
//   feature  unsigned activation (DATA_WIDTH)
//   kernel   two's-complement weight (DATA_WIDTH)
//   product  signed product (2*DATA_WIDTH+1), exact for all operand values
// ---------------------------------------------------------------------------
module mac_pe #(
  parameter int DATA_WIDTH = cnn_defs::DFLT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]            feature,
  input  logic [DATA_WIDTH-1:0]            kernel,
  output logic signed [2*DATA_WIDTH:0]     product
);

  localparam int PROD_W = 2 * DATA_WIDTH + 1;

  logic signed [PROD_W-1:0] feat_ext;
  logic signed [PROD_W-1:0] kern_ext;

  // The leading zero keeps a full-scale activation positive (255 stays +255).
  assign feat_ext = PROD_W'($signed({1'b0, feature}));
  assign kern_ext = PROD_W'($signed(kernel));
  assign product  = feat_ext * kern_ext;

endmodule

// File: rtl/mac.sv
// ---------------------------------------------------------------------------
// mac : KERNEL_SIZE x KERNEL_SIZE multiply-accumulate (dot product of an
// unsigned activation window with a signed weight window).
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    mac_if.slave : in_valid/feature/kernel in, result/out_valid out
// Build option MAC_PIPE_EN:
//   defined   : products registered, then the tree sum registered; result and
//               out_valid appear two cycles after the window is presented,
//               one window per cycle, result holds while out_valid is low.
//   undefined : purely combinational, out_valid = in_valid; clk/reset unused.
// ---------------------------------------------------------------------------
module mac
  import cnn_defs::*;
#(
  parameter int DATA_WIDTH       = DFLT_DATA_WIDTH,
  parameter int KERNEL_SIZE      = DFLT_KERNEL_SIZE,
  parameter int MAC_RESULT_WIDTH = DFLT_MAC_RESULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  mac_if.slave bus
);

  localparam int NUM_TAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PROD_W   = 2 * DATA_WIDTH + 1;
  localparam int SUM_W    = mac_sum_width(DATA_WIDTH, KERNEL_SIZE);

  // With this check in place the sum can never overflow the result width.
  if (MAC_RESULT_WIDTH < SUM_W) begin : g_width_check
    $error("mac: MAC_RESULT_WIDTH (%0d) smaller than required sum width (%0d)",
           MAC_RESULT_WIDTH, SUM_W);
  end

  function automatic logic signed [MAC_RESULT_WIDTH-1:0] sext_result(
    input logic signed [SUM_W-1:0] s
  );
    return MAC_RESULT_WIDTH'(s);
  endfunction

  logic signed [PROD_W-1:0] prod [NUM_TAPS];

  for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_row
    for (genvar j = 0; j < KERNEL_SIZE; j++) begin : g_col
      mac_pe #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_pe (
        .feature (bus.feature[i][j]),
        .kernel  (bus.kernel[i][j]),
        .product (prod[i*KERNEL_SIZE+j])
      );
    end
  end

`ifdef MAC_PIPE_EN

  logic signed [PROD_W-1:0]           prod_p1 [NUM_TAPS];
  logic                               vld_p1;
  logic signed [SUM_W-1:0]            sum_p1;
  logic signed [MAC_RESULT_WIDTH-1:0] result_p2;
  logic                               vld_p2;

  // ---- stage 1: register every product ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      for (int t = 0; t < NUM_TAPS; t++) prod_p1[t] <= '0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        for (int t = 0; t < NUM_TAPS; t++) prod_p1[t] <= prod[t];
      end
    end
  end

  always_comb begin
    sum_p1 = '0;
    for (int t = 0; t < NUM_TAPS; t++) sum_p1 = sum_p1 + SUM_W'(prod_p1[t]);
  end

  // ---- stage 2: register the tree sum, hold it between valid results ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) result_p2 <= sext_result(sum_p1);
    end
  end

  assign bus.result    = result_p2;
  assign bus.out_valid = vld_p2;

`else

  logic signed [SUM_W-1:0] sum_p0;
  logic                    unused_clk_reset;

  always_comb begin
    sum_p0 = '0;
    for (int t = 0; t < NUM_TAPS; t++) sum_p0 = sum_p0 + SUM_W'(prod[t]);
  end

  assign bus.result       = sext_result(sum_p0);
  assign bus.out_valid    = bus.in_valid;
  assign unused_clk_reset = clk ^ reset;

`endif

endmodule

// File: tb/tb_mac.sv
module tb_mac;

  localparam int DW = 8;
  localparam int KS = 3;
  localparam int RW = 32;
`ifdef MAC_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int NV = 12;

  typedef struct {
    logic               vld;
    logic [71:0]        feat;
    logic [71:0]        kern;
    logic signed [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vec_t tbl [NV];
  logic signed [31:0] held;

  mac_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .MAC_RESULT_WIDTH(RW)) bus ();

  mac #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .MAC_RESULT_WIDTH(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // element n = row*3+col sits at bits [n*8 +: 8]
  function automatic logic [71:0] fill(input int v);
    logic [71:0] r;
    for (int n = 0; n < 9; n++) r[n*8 +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [71:0] seq(input int start, input int step);
    logic [71:0] r;
    for (int n = 0; n < 9; n++) r[n*8 +: 8] = 8'(start + step * n);
    return r;
  endfunction

  function automatic logic [71:0] cols3(input int a, input int b, input int c);
    logic [71:0] r;
    for (int n = 0; n < 9; n++) r[n*8 +: 8] = (n % 3 == 0) ? 8'(a) : (n % 3 == 1) ? 8'(b) : 8'(c);
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [71:0] f, input logic [71:0] k);
    bus.in_valid = v;
    bus.feature  = f;
    bus.kernel   = k;
  endtask

  initial begin
    logic [71:0] ctr_f;
    logic [71:0] ctr_k;

    ctr_f = fill(7);
    ctr_f[32 +: 8] = 8'd200;
    ctr_k = fill(0);
    ctr_k[32 +: 8] = 8'd1;

    tbl[0]  = '{1'b1, seq(1, 1),  fill(1),           32'sd45};
    tbl[1]  = '{1'b1, fill(255),  fill(-128),        -32'sd293760};
    tbl[2]  = '{1'b1, ctr_f,      ctr_k,             32'sd200};
    tbl[3]  = '{1'b1, fill(10),   cols3(1, 0, -1),   32'sd0};
    tbl[4]  = '{1'b1, fill(10),   fill(-1),          -32'sd90};
    tbl[5]  = '{1'b0, fill(99),   fill(5),           32'sd0};
    tbl[6]  = '{1'b0, fill(3),    fill(-7),          32'sd0};
    tbl[7]  = '{1'b1, seq(1, 1),  seq(1, 1),         32'sd285};
    tbl[8]  = '{1'b0, fill(50),   fill(50),          32'sd0};
    tbl[9]  = '{1'b1, fill(255),  fill(127),         32'sd291465};
    tbl[10] = '{1'b1, seq(1, 1),  seq(-1, -1),       -32'sd285};
    tbl[11] = '{1'b1, fill(0),    fill(-77),         32'sd0};

    drive(1'b0, '0, '0);
    #2 reset = 1'b1;
    #1;
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk("reset_result", longint'(bus.result), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    held = 32'sd0;

    // streamed table: slot c is presented in cycle c, its result checked LAT cycles later
    for (int c = 0; c < NV + LAT; c++) begin
      @(negedge clk);
      if (c < NV) drive(tbl[c].vld, tbl[c].feat, tbl[c].kern);
      else        drive(1'b0, '0, '0);
      #1;
      if (c >= LAT) begin
        chk($sformatf("vec%0d_out_valid", c - LAT), longint'(bus.out_valid), longint'(tbl[c-LAT].vld));
        if (tbl[c-LAT].vld) begin
          chk($sformatf("vec%0d_result", c - LAT), longint'(bus.result), longint'(tbl[c-LAT].exp));
          held = tbl[c-LAT].exp;
        end else if (LAT > 0) begin
          chk($sformatf("vec%0d_hold", c - LAT), longint'(bus.result), longint'(held));
        end
      end else begin
        chk($sformatf("fill%0d_out_valid", c), longint'(bus.out_valid), 0);
      end
    end

`ifdef MAC_PIPE_EN
    // two windows in flight, async reset, then a third window
    @(negedge clk); drive(1'b1, fill(1), fill(1));
    @(negedge clk); drive(1'b1, fill(2), fill(1));
    @(negedge clk); drive(1'b0, '0, '0);
    #1;
    chk("rst_seq_first_out", longint'(bus.result), 9);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_out_valid", longint'(bus.out_valid), 0);
    chk("rst_async_result", longint'(bus.result), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, fill(3), fill(1));
    #1;
    chk("rst_post_c0_out_valid", longint'(bus.out_valid), 0);
    @(negedge clk); drive(1'b0, '0, '0);
    #1;
    chk("rst_post_c1_out_valid", longint'(bus.out_valid), 0);
    chk("rst_post_c1_result", longint'(bus.result), 0);
    @(negedge clk); #1;
    chk("rst_third_out_valid", longint'(bus.out_valid), 1);
    chk("rst_third_result", longint'(bus.result), 27);
    @(negedge clk); #1;
    chk("rst_after_out_valid", longint'(bus.out_valid), 0);
    chk("rst_after_hold", longint'(bus.result), 27);
`else
    // combinational build: result follows the inputs in the same cycle
    @(negedge clk); drive(1'b1, seq(1, 1), fill(1));
    #1;
    chk("comb_out_valid", longint'(bus.out_valid), 1);
    chk("comb_result", longint'(bus.result), 45);
    drive(1'b0, fill(2), fill(-3));
    #1;
    chk("comb_out_valid_low", longint'(bus.out_valid), 0);
    chk("comb_result_follow", longint'(bus.result), -54);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
